rvvi_retire_buffer: RTL
=======================

# rvvi_retire_buffer

Retirement capture stage directly upstream of the RVVI trace interface. Accepts one retired-instruction event per cycle from the core's commit port, buffers it in a small FIFO, and assigns a gap-free 64-bit order number. It maintains a shadow X register file and emits one trace slot per cycle in the form the trace interface consumes (single hart, RETIRE=1). Back-pressure from the trace sink holds events in the buffer; no event is ever dropped.

## Interface
- ILEN, 32, instruction width in bits
- XLEN, 32, GPR/PC/CSR data width in bits
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  interface clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  commit event offered
- in_ready  out  1  buffer can accept; transfer when in_valid && in_ready
- in_insn  in  ILEN  instruction bits
- in_pc  in  XLEN  PC of instruction
- in_pc_next  in  XLEN  PC of next instruction
- in_trap  in  1  event is a trap (no retirement)
- in_debug  in  1  executed in debug mode
- in_mode  in  2  privilege mode
- in_rd_we / in_rd / in_rd_data  in  1 / 5 / XLEN  GPR writeback
- in_csr_we / in_csr_addr / in_csr_data  in  1 / 12 / XLEN  CSR writeback
- out_stall  in  1  sink not consuming this cycle
- valid  out  1  trace slot valid (one pulse per event)
- order  out  64  event order number
- insn, trap, debug_mode, pc_rdata, pc_wdata, mode  out  ILEN, 1, 1, XLEN, XLEN, 2  event fields
- x_wdata  out  32×XLEN  full shadow X register file
- x_wb  out  32  one-hot writeback flag
- csr_wb / csr_addr / csr_wdata  out  1 / 12 / XLEN  CSR writeback
- pc_err  out  1  sticky PC continuity error

## Operation
- Reset: all outputs 0, FIFO empty, in_ready=1, shadow regs all 0, next order = 1.
- Push: on transfer, event written at write pointer; pointers wrap modulo DEPTH.
- in_ready = (count < DEPTH), from registered count only; a full buffer stays not-ready in a cycle where it also pops (no same-cycle push-through when full).
- Pop: when count>0 and !out_stall, head entry is registered onto outputs with valid=1 next cycle; otherwise valid=0 and event fields hold their last values.
- order: value of next-order counter at pop, then counter += 1; increments only on pop, so emitted orders are 1,2,3,… with no gaps; 64-bit wrap to 0 permitted (not reachable in practice).
- GPR: if rd_we && rd≠0 && !trap: shadow[rd] ← rd_data at pop, x_wb = 1<<rd, x_wdata shows updated file in the same cycle as valid. Writes to x0 or on trap: x_wb=0, shadow unchanged; shadow[0] always 0.
- CSR: csr_wb/csr_addr/csr_wdata copied from entry, trap or not (traps update cause/epc).
- x_wb and csr_wb are 0 whenever valid=0.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged. Push into empty buffer while !out_stall: event emerges next cycle.
- Reset mid-operation: buffered events discarded, order restarts at 1, shadow cleared.

## Timing
- Latency in_valid transfer (edge N) → valid high after edge N+1, empty buffer, out_stall=0.
- Throughput one event/cycle sustained with out_stall=0.
- out_stall sampled at the same edge that would pop; a stall asserted for k cycles delays the head by exactly k cycles.
- in_ready deasserts the cycle after the DEPTH-th entry is accepted without a pop.

## Configuration
- RVVI_RETIRE_BUF_PC_CHECK_EN defined: at each pop, if previous popped event was not a trap and this pc_rdata ≠ previous pc_wdata, pc_err set next cycle; sticky until reset. Check skipped on the first event after reset and on the event after a trap.
- Not defined: no check logic; pc_err tied 0.

## Test plan
- Single event: insn=0x00500093, pc=0x80000000, rd=1, data=5 → one valid pulse at N+1, order=1, x_wb=0x2, x_wdata[1]=5.
- Stream of 10 back-to-back events, out_stall=0 → 10 consecutive valid cycles, orders 1..10, in_ready held 1.
- out_stall=1 for 8 cycles while pushing 6 events, DEPTH=4 → in_ready=0 after 4 accepted, no valid; release → orders 1..4 then 5,6 in order, none lost.
- Write x0 data=0xFFFF and trap event with rd=3 → x_wb=0 both, x_wdata[0]=0, x_wdata[3] unchanged; trap event csr_wb=1 addr=0x342 forwarded.
- Reset asserted with 3 entries queued → all outputs 0 immediately; next event after release has order=1.
- With macro: event pc_next=0x80000004 followed by pc=0x80000010 (non-trap) → pc_err=1 and stays 1; without macro pc_err=0.

Source files
------------

// File: rtl/rvvi_retire_buffer_if.sv
// rtl/rvvi_retire_buffer_if.sv - commit-port and trace-slot bundle for rvvi_retire_buffer
//
// Purpose: groups the core commit handshake (in_*), the sink stall and the
// RVVI trace slot outputs into one interface.
// Modports:
//   master - core/sink side: drives in_* and out_stall, observes everything else
//   slave  - retire buffer side: consumes in_* and out_stall, drives in_ready and trace slot
interface rvvi_retire_buffer_if #(
  parameter int ILEN = 32,
  parameter int XLEN = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ILEN-1:0]       in_insn;
  logic [XLEN-1:0]       in_pc;
  logic [XLEN-1:0]       in_pc_next;
  logic                  in_trap;
  logic                  in_debug;
  logic [1:0]            in_mode;
  logic                  in_rd_we;
  logic [4:0]            in_rd;
  logic [XLEN-1:0]       in_rd_data;
  logic                  in_csr_we;
  logic [11:0]           in_csr_addr;
  logic [XLEN-1:0]       in_csr_data;
  logic                  out_stall;
  logic                  valid;
  logic [63:0]           order;
  logic [ILEN-1:0]       insn;
  logic                  trap;
  logic                  debug_mode;
  logic [XLEN-1:0]       pc_rdata;
  logic [XLEN-1:0]       pc_wdata;
  logic [1:0]            mode;
  logic [31:0][XLEN-1:0] x_wdata;
  logic [31:0]           x_wb;
  logic                  csr_wb;
  logic [11:0]           csr_addr;
  logic [XLEN-1:0]       csr_wdata;
  logic                  pc_err;

  modport master (
    output in_valid, in_insn, in_pc, in_pc_next, in_trap, in_debug, in_mode,
           in_rd_we, in_rd, in_rd_data, in_csr_we, in_csr_addr, in_csr_data,
           out_stall,
    input  in_ready, valid, order, insn, trap, debug_mode, pc_rdata, pc_wdata,
           mode, x_wdata, x_wb, csr_wb, csr_addr, csr_wdata, pc_err
  );

  modport slave (
    input  in_valid, in_insn, in_pc, in_pc_next, in_trap, in_debug, in_mode,
           in_rd_we, in_rd, in_rd_data, in_csr_we, in_csr_addr, in_csr_data,
           out_stall,
    output in_ready, valid, order, insn, trap, debug_mode, pc_rdata, pc_wdata,
           mode, x_wdata, x_wb, csr_wb, csr_addr, csr_wdata, pc_err
  );
endinterface

// File: rtl/rvvi_retire_buffer.sv
// rtl/rvvi_retire_buffer.sv - retirement FIFO with order numbering and shadow X file for RVVI
//
// Purpose: buffers commit events in a DEPTH-entry FIFO, pops one per cycle
// unless the sink stalls, numbers popped events 1,2,3,... and keeps a shadow
// GPR file so every trace slot carries the full post-retire X register state.
// Ports:
//   clk   - clock, all state on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - rvvi_retire_buffer_if.slave (commit handshake in, trace slot out)
// Optional feature: define RVVI_RETIRE_BUF_PC_CHECK_EN to enable the sticky
// PC continuity check on pc_err; otherwise pc_err is tied to 0.
module rvvi_retire_buffer #(
  parameter int ILEN  = 32,
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  rvvi_retire_buffer_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            trap;
    logic            debug;
    logic [1:0]      mode;
    logic            rd_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_data;
  } entry_t;

  entry_t                r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic [63:0]           r_next_order;
  logic [31:0][XLEN-1:0] r_shadow;

  logic                  r_valid;
  logic [63:0]           r_order;
  logic [ILEN-1:0]       r_insn;
  logic                  r_trap;
  logic                  r_debug;
  logic [XLEN-1:0]       r_pc_rdata;
  logic [XLEN-1:0]       r_pc_wdata;
  logic [1:0]            r_mode;
  logic [31:0]           r_x_wb;
  logic                  r_csr_wb;
  logic [11:0]           r_csr_addr;
  logic [XLEN-1:0]       r_csr_wdata;

  entry_t w_in_entry;
  entry_t w_head;
  logic   w_push;
  logic   w_pop;
  logic   w_gpr_wr;

  // Ready depends only on the registered count: a full buffer never accepts,
  // even in a cycle where it also pops.
  assign bus.in_ready = (r_count < CNT_FULL);
  assign w_push       = bus.in_valid && bus.in_ready;
  assign w_pop        = (r_count != '0) && !bus.out_stall;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_gpr_wr     = w_head.rd_we && (w_head.rd != 5'd0) && !w_head.trap;

  assign w_in_entry = '{
    insn:     bus.in_insn,
    pc:       bus.in_pc,
    pc_next:  bus.in_pc_next,
    trap:     bus.in_trap,
    debug:    bus.in_debug,
    mode:     bus.in_mode,
    rd_we:    bus.in_rd_we,
    rd:       bus.in_rd,
    rd_data:  bus.in_rd_data,
    csr_we:   bus.in_csr_we,
    csr_addr: bus.in_csr_addr,
    csr_data: bus.in_csr_data
  };

  // Storage carries no reset: stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_next_order <= 64'd1;
      r_shadow     <= '0;
      r_valid      <= 1'b0;
      r_order      <= '0;
      r_insn       <= '0;
      r_trap       <= 1'b0;
      r_debug      <= 1'b0;
      r_pc_rdata   <= '0;
      r_pc_wdata   <= '0;
      r_mode       <= '0;
      r_x_wb       <= '0;
      r_csr_wb     <= 1'b0;
      r_csr_addr   <= '0;
      r_csr_wdata  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      r_valid <= w_pop;
      if (w_pop) begin
        r_order      <= r_next_order;
        r_next_order <= r_next_order + 64'd1;
        r_insn       <= w_head.insn;
        r_trap       <= w_head.trap;
        r_debug      <= w_head.debug;
        r_pc_rdata   <= w_head.pc;
        r_pc_wdata   <= w_head.pc_next;
        r_mode       <= w_head.mode;
        r_csr_wb     <= w_head.csr_we;
        r_csr_addr   <= w_head.csr_addr;
        r_csr_wdata  <= w_head.csr_data;
        r_x_wb       <= w_gpr_wr ? (32'd1 << w_head.rd) : 32'd0;
        if (w_gpr_wr) r_shadow[w_head.rd] <= w_head.rd_data;
      end else begin
        r_x_wb   <= '0;
        r_csr_wb <= 1'b0;
      end
    end
  end

`ifdef RVVI_RETIRE_BUF_PC_CHECK_EN
  // r_chk_armed: a previous non-trap event exists whose pc_next is the
  // expected pc of the next popped event.
  logic            r_pc_err;
  logic            r_chk_armed;
  logic [XLEN-1:0] r_prev_pc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_err       <= 1'b0;
      r_chk_armed    <= 1'b0;
      r_prev_pc_next <= '0;
    end else if (w_pop) begin
      if (r_chk_armed && (w_head.pc != r_prev_pc_next)) r_pc_err <= 1'b1;
      r_chk_armed    <= !w_head.trap;
      r_prev_pc_next <= w_head.pc_next;
    end
  end

  assign bus.pc_err = r_pc_err;
`else
  assign bus.pc_err = 1'b0;
`endif

  assign bus.valid      = r_valid;
  assign bus.order      = r_order;
  assign bus.insn       = r_insn;
  assign bus.trap       = r_trap;
  assign bus.debug_mode = r_debug;
  assign bus.pc_rdata   = r_pc_rdata;
  assign bus.pc_wdata   = r_pc_wdata;
  assign bus.mode       = r_mode;
  assign bus.x_wdata    = r_shadow;
  assign bus.x_wb       = r_x_wb;
  assign bus.csr_wb     = r_csr_wb;
  assign bus.csr_addr   = r_csr_addr;
  assign bus.csr_wdata  = r_csr_wdata;
endmodule
